// File: rtl/com_gesture_filter.sv
// com_gesture_filter
//   Turns the per-frame centroid from center_of_mass into debounced,
//   one-shot rotate commands for game_state. Each valid_in frame is
//   classified against a square dead zone around screen center. A
//   direction must persist for STABLE_FRAMES frames before it fires. The
//   filter then stays latched until the gesture is released and a
//   cooldown of COOLDOWN_FRAMES neutral frames has elapsed.
//
//   Optional feature macro: COM_GESTURE_AUTOREPEAT_EN
//     When defined, holding the fired direction re-fires every
//     REPEAT_FRAMES frames. The REPEAT_FRAMES parameter only exists in
//     that build.
//
// Ports
//   clk_in        pixel clock
//   rst_in        asynchronous, active-low reset
//   x_in, y_in    centroid, sampled when valid_in=1
//   valid_in      one-cycle pulse per frame
//   cmd_out       00 up, 01 down, 10 right, 11 left; holds its last value
//   cmd_valid_out one-cycle command strobe, one clock after the firing frame
//   neutral_out   1 when the last classified frame was neutral
//   state_out     FSM state: 0 IDLE, 1 TRACK, 2 HOLD, 3 COOL
`timescale 1ns/1ps
module com_gesture_filter #(
    parameter int H_CENTER        = 512,
    parameter int V_CENTER        = 384,
    parameter int DEAD_ZONE       = 96,
    parameter int STABLE_FRAMES   = 4,
    parameter int COOLDOWN_FRAMES = 8
`ifdef COM_GESTURE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_FRAMES   = 16
`endif
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    output logic [1:0]  cmd_out,
    output logic        cmd_valid_out,
    output logic        neutral_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2,
        COOL  = 2'd3
    } state_t;

    // Classification. Offsets are two's complement; magnitudes at 12 bits.
    logic [11:0] dx;
    logic [10:0] dy;
    logic [11:0] dy_ext;
    logic [11:0] mag_x;
    logic [11:0] mag_y;
    logic        is_neutral;
    logic        dx_pos;
    logic [1:0]  dir;

    assign dx         = {1'b0, x_in} - 12'(H_CENTER);
    assign dy         = {1'b0, y_in} - 11'(V_CENTER);
    assign dy_ext     = {dy[10], dy};
    assign mag_x      = dx[11] ? (12'd0 - dx) : dx;
    assign mag_y      = dy_ext[11] ? (12'd0 - dy_ext) : dy_ext;
    assign is_neutral = (mag_x <= 12'(DEAD_ZONE)) && (mag_y <= 12'(DEAD_ZONE));
    assign dx_pos     = !dx[11] && (dx != 12'd0);

    // Ties between the axes resolve to vertical.
    always_comb begin
        if (mag_x > mag_y) begin
            dir = dx_pos ? 2'b10 : 2'b11;
        end else begin
            dir = dy[10] ? 2'b00 : 2'b01;
        end
    end

    state_t      state_q, state_d;
    logic [1:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;
    logic [7:0]  cool_q, cool_d;
    logic        fire_q, fire_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        neutral_q, neutral_d;
`ifdef COM_GESTURE_AUTOREPEAT_EN
    logic [7:0]  rep_q, rep_d;
    logic [7:0]  rep_inc;
    assign rep_inc = rep_q + 8'd1;
`endif

    // Saturating frame counter: a long streak never wraps back below the threshold.
    assign cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        cool_d      = cool_q;
        neutral_d   = neutral_q;
        fire_d      = 1'b0;
        // A fire decided on a frame edge is presented on the following edge.
        cmd_valid_d = fire_q;
        cmd_d       = fire_q ? cand_q : cmd_q;
`ifdef COM_GESTURE_AUTOREPEAT_EN
        rep_d       = rep_q;
`endif
        if (valid_in) begin
            neutral_d = is_neutral;
`ifdef COM_GESTURE_AUTOREPEAT_EN
            // Only a same-direction frame in HOLD keeps the repeat count alive.
            rep_d     = 8'd0;
`endif
            case (state_q)
                IDLE: begin
                    if (!is_neutral) begin
                        cand_d = dir;
                        cnt_d  = 4'd1;
                        if (STABLE_FRAMES == 1) begin
                            fire_d  = 1'b1;
                            state_d = HOLD;
                        end else begin
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (is_neutral) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (dir != cand_q) begin
                        cand_d = dir;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= 4'(STABLE_FRAMES)) begin
                            fire_d  = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (is_neutral) begin
                        if (COOLDOWN_FRAMES == 0) begin
                            state_d = IDLE;
                        end else begin
                            cool_d  = 8'(COOLDOWN_FRAMES);
                            state_d = COOL;
                        end
                    end
`ifdef COM_GESTURE_AUTOREPEAT_EN
                    else if (dir == cand_q) begin
                        if (rep_inc >= 8'(REPEAT_FRAMES)) begin
                            fire_d = 1'b1;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end
`endif
                end
                COOL: begin
                    if (is_neutral) begin
                        cool_d = cool_q - 8'd1;
                        if (cool_q == 8'd1) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cand_q      <= 2'b00;
            cnt_q       <= 4'd0;
            cool_q      <= 8'd0;
            fire_q      <= 1'b0;
            cmd_q       <= 2'b00;
            cmd_valid_q <= 1'b0;
            neutral_q   <= 1'b1;
`ifdef COM_GESTURE_AUTOREPEAT_EN
            rep_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            cool_q      <= cool_d;
            fire_q      <= fire_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            neutral_q   <= neutral_d;
`ifdef COM_GESTURE_AUTOREPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign cmd_out       = cmd_q;
    assign cmd_valid_out = cmd_valid_q;
    assign neutral_out   = neutral_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_com_gesture_filter.sv
// tb_com_gesture_filter
//   Drives com_gesture_filter with directed gesture scenarios and a long
//   randomized frame sequence. A frame-level reference model (streak
//   length, armed/latched flag, cooldown frames left) predicts every
//   output each cycle; directed scenarios also check literal results.
`timescale 1ns/1ps
module tb_com_gesture_filter;

    localparam int H      = 512;
    localparam int V      = 384;
    localparam int DZ     = 96;
    localparam int STABLE = 4;
    localparam int COOLF  = 8;
    localparam int REP    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic [1:0]  cmd_out;
    logic        cmd_valid_out;
    logic        neutral_out;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int last_cmd = 0;

    always #5 clk = ~clk;

    com_gesture_filter dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .x_in          (x_in),
        .y_in          (y_in),
        .valid_in      (valid_in),
        .cmd_out       (cmd_out),
        .cmd_valid_out (cmd_valid_out),
        .neutral_out   (neutral_out),
        .state_out     (state_out)
    );

    // ---------------- reference model ----------------
    bit         m_armed;
    int         m_len;
    int         m_dir;
    int         m_cool;
    int         m_rep;
    bit         m_pend;
    int         m_pend_cmd;
    logic [1:0] exp_cmd;
    logic       exp_cv;
    logic       exp_neutral;

    // -1 neutral, else direction code
    function automatic int classify(int x, int y);
        int dx, dy, ax, ay;
        dx = x - H;
        dy = y - V;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        if (ax <= DZ && ay <= DZ) return -1;
        if (ax > ay) return (dx > 0) ? 2 : 3;
        return (dy < 0) ? 0 : 1;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_armed) return (m_len > 0) ? 2'd1 : 2'd0;
        return (m_cool > 0) ? 2'd3 : 2'd2;
    endfunction

    task automatic model_reset();
        m_armed = 1; m_len = 0; m_dir = 0; m_cool = 0; m_rep = 0;
        m_pend = 0; m_pend_cmd = 0;
        exp_cmd = 2'b00; exp_cv = 1'b0; exp_neutral = 1'b1;
    endtask

    task automatic model_fire(int d);
        m_pend = 1;
        m_pend_cmd = d;
    endtask

    task automatic model_frame(int c);
        exp_neutral = (c < 0);
        if (m_armed) begin
            if (c < 0) begin
                m_len = 0;
            end else begin
                if (m_len > 0 && c == m_dir) m_len++;
                else begin m_dir = c; m_len = 1; end
                if (m_len >= STABLE) begin
                    model_fire(m_dir);
                    m_armed = 0; m_cool = 0; m_rep = 0;
                end
            end
        end else if (c < 0) begin
            if (m_cool == 0) begin
                if (COOLF == 0) begin m_armed = 1; m_len = 0; end
                else m_cool = COOLF;
            end else begin
                m_cool--;
                if (m_cool == 0) begin m_armed = 1; m_len = 0; end
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
            m_rep = 0;
        end else begin
`ifdef COM_GESTURE_AUTOREPEAT_EN
            if (c == m_dir) begin
                m_rep++;
                if (m_rep == REP) begin model_fire(m_dir); m_rep = 0; end
            end else begin
                m_rep = 0;
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                exp_cv = m_pend;
                if (m_pend) exp_cmd = 2'(m_pend_cmd);
                m_pend = 0;
                if (valid_in) model_frame(classify(int'(x_in), int'(y_in)));
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks++;
            if (cmd_valid_out !== exp_cv || cmd_out !== exp_cmd ||
                neutral_out !== exp_neutral || state_out !== exp_state()) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got cv=%b cmd=%b neu=%b st=%0d expected cv=%b cmd=%b neu=%b st=%0d",
                         $time, cmd_valid_out, cmd_out, neutral_out, state_out,
                         exp_cv, exp_cmd, exp_neutral, exp_state());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid_out === 1'b1) begin
                pulses++;
                last_cmd = int'(cmd_out);
                $display("pulse t=%0t cmd=%b", $time, cmd_out);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic frame(input int x, input int y);
        @(negedge clk);
        x_in = 11'(x);
        y_in = 10'(y);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic frames(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) frame(x, y);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic release_to_idle(input string name);
        frames(H, V, 10);
        settle();
        check(name, int'(state_out), 0);
    endtask

    // ---------------- stimulus ----------------
    int base;
    int px, py, r, gap;
    bit have_prev;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_cmd", int'(cmd_out), 0);
        check("reset_cv", int'(cmd_valid_out), 0);
        check("reset_neutral", int'(neutral_out), 1);
        check("reset_state", int'(state_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Neutral frames never fire.
        base = pulses;
        frames(512, 384, 10);
        settle();
        check("idle_pulses", pulses - base, 0);
        check("idle_neutral", int'(neutral_out), 1);

        // Debounce with exact latency.
        base = pulses;
        frames(800, 400, 4);
        check("deb_state_hold", int'(state_out), 2);
        check("deb_cv_not_yet", int'(cmd_valid_out), 0);
        @(negedge clk);
        check("deb_cv_rise", int'(cmd_valid_out), 1);
        check("deb_cmd", int'(cmd_out), 2);
        @(negedge clk);
        check("deb_cv_fall", int'(cmd_valid_out), 0);
        check("deb_pulses", pulses - base, 1);
        release_to_idle("deb_release");

        base = pulses;
        frames(800, 400, 3);
        frame(512, 384);
        settle();
        check("short_pulses", pulses - base, 0);
        check("short_state", int'(state_out), 0);

        // Boundaries.
        frame(608, 384);
        settle();
        check("b608_neutral", int'(neutral_out), 1);
        check("b608_state", int'(state_out), 0);
        base = pulses;
        frames(609, 384, 4);
        settle();
        check("b609_pulses", pulses - base, 1);
        check("b609_cmd", last_cmd, 2);
        release_to_idle("b609_release");
        frame(600, 296);
        settle();
        check("b600_neutral", int'(neutral_out), 1);
        base = pulses;
        frames(700, 196, 4);
        settle();
        check("tie_pulses", pulses - base, 1);
        check("tie_cmd", last_cmd, 0);
        release_to_idle("tie_release");

        // Direction switch.
        base = pulses;
        frames(100, 384, 2);
        frames(512, 700, 4);
        settle();
        check("switch_pulses", pulses - base, 1);
        check("switch_cmd", last_cmd, 1);
        release_to_idle("switch_release");

        // Cooldown: release frame loads 8, eight more neutral frames reach 0.
        base = pulses;
        frames(800, 400, 4);
        frame(512, 384);
        settle();
        check("cool_state", int'(state_out), 3);
        frames(800, 400, 4);
        settle();
        check("cool_back_hold", int'(state_out), 2);
        check("cool_pulses", pulses - base, 1);
        frames(512, 384, 1 + COOLF);
        settle();
        check("cool_rearmed", int'(state_out), 0);
        frames(800, 400, 4);
        settle();
        check("cool_refire", pulses - base, 2);
        release_to_idle("cool_release");

        // Long hold.
        base = pulses;
        frames(100, 384, 36);
        settle();
`ifdef COM_GESTURE_AUTOREPEAT_EN
        check("hold_pulses", pulses - base, 3);
`else
        check("hold_pulses", pulses - base, 1);
`endif
        check("hold_cmd", last_cmd, 3);
        release_to_idle("hold_release");

        // Reset while a fire is pending.
        base = pulses;
        frames(100, 384, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_cv", int'(cmd_valid_out), 0);
        check("rst_cmd", int'(cmd_out), 0);
        check("rst_state", int'(state_out), 0);
        check("rst_neutral", int'(neutral_out), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("rst_no_pulse", pulses - base, 0);

        // Randomized frames against the model.
        have_prev = 0;
        px = H; py = V;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                @(negedge clk);
                valid_in = 1'b0;
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            r = int'($urandom_range(0, 99));
            if (r < 40 && have_prev) begin
                // keep previous point
            end else if (r < 70) begin
                px = int'($urandom_range(400, 624));
                py = int'($urandom_range(272, 496));
            end else begin
                px = int'($urandom_range(0, 2047));
                py = int'($urandom_range(0, 1023));
            end
            have_prev = 1;
            @(negedge clk);
            x_in = 11'(px);
            y_in = 10'(py);
            valid_in = 1'b1;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                @(negedge clk);
                valid_in = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
